// File: rtl/wb_sequencer_pkg.sv
// wb_pkg: shared definitions for the writeback sequencer.
//   - writeback mux source encodings (value driven on sign)
//   - sequencer state encoding
//   - wait-counter width
package wb_pkg;

  localparam int CNT_W = 8;

  typedef enum logic [2:0] {
    SRC_RAM = 3'd0,
    SRC_ALU = 3'd1,
    SRC_IN  = 3'd2,
    SRC_EXT = 3'd3,
    SRC_HD  = 3'd4
  } wb_src_e;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_RAM_WAIT = 3'd1,
    ST_HD_REQ   = 3'd2,
    ST_IN_WAIT  = 3'd3,
    ST_WRITE    = 3'd4
  } wb_state_e;

  function automatic logic src_legal(input logic [2:0] src);
    return src <= 3'd4;
  endfunction

endpackage

// File: rtl/wb_sequencer_if.sv
// wb_sequencer_if: request/response bundle between the datapath control
// and the writeback sequencer.
//   master: drives wbValid, wbSrc, wbRd, wbRegWrite, flush, hdAck, inEnter
//   slave : drives sign, regWrite, regAddr, hdReq, inWait, stall, err
interface wb_sequencer_if;
  logic       wbValid;
  logic [2:0] wbSrc;
  logic [4:0] wbRd;
  logic       wbRegWrite;
  logic       flush;
  logic       hdAck;
  logic       inEnter;
  logic [2:0] sign;
  logic       regWrite;
  logic [4:0] regAddr;
  logic       hdReq;
  logic       inWait;
  logic       stall;
  logic       err;

  modport master (
    output wbValid, wbSrc, wbRd, wbRegWrite, flush, hdAck, inEnter,
    input  sign, regWrite, regAddr, hdReq, inWait, stall, err
  );

  modport slave (
    input  wbValid, wbSrc, wbRd, wbRegWrite, flush, hdAck, inEnter,
    output sign, regWrite, regAddr, hdReq, inWait, stall, err
  );
endinterface

// File: rtl/wb_wait_counter.sv
// wb_wait_counter: loadable down-counter shared by the RAM latency wait and
// the HD handshake timeout.
//   clk, rst_n : clock, async active-low reset (count clears to 0)
//   load       : load load_val (takes priority over en)
//   en         : decrement, saturating at 0
//   zero       : count is 0
module wb_wait_counter
  import wb_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             en,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero
);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (en && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero = (count_q == '0);

endmodule

// File: rtl/wb_sequencer.sv
// wb_sequencer: writeback controller for the multi-cycle MIPS datapath.
// Accepts one request at a time, selects the writeback mux source, waits for
// slow sources and issues a single register-file write pulse.
//   clk, rst_n : clock, async active-low reset
//   bus        : wb_sequencer_if.slave (request in, mux select / write / status out)
//
// state       | meaning
// ------------+-----------------------------------------------------
// ST_IDLE     | ready; wbValid sampled only here
// ST_RAM_WAIT | counting down RAM read latency
// ST_HD_REQ   | hdReq high, waiting for hdAck or timeout
// ST_IN_WAIT  | inWait high, waiting for the user confirm pulse
// ST_WRITE    | regWrite pulse (suppressed for $zero), then back to idle
module wb_sequencer
  import wb_pkg::*;
#(
  parameter int RAM_LAT    = 2,
  parameter int HD_TIMEOUT = 255
) (
  input logic           clk,
  input logic           rst_n,
  wb_sequencer_if.slave bus
);

  localparam logic [CNT_W-1:0] RAM_LOAD = CNT_W'(RAM_LAT - 1);
  localparam logic [CNT_W-1:0] HD_LOAD  = CNT_W'(HD_TIMEOUT - 1);

  wb_state_e  state_q, state_d;
  logic [2:0] sign_q, sign_d;
  logic       reg_write_q, reg_write_d;
  logic [4:0] reg_addr_q, reg_addr_d;
  logic       hd_req_q, hd_req_d;
  logic       in_wait_q, in_wait_d;
  logic       err_q, err_d;

  logic             cnt_load, cnt_en, cnt_zero;
  logic [CNT_W-1:0] cnt_load_val;

  wb_wait_counter u_wait_counter (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (cnt_load),
    .en       (cnt_en),
    .load_val (cnt_load_val),
    .zero     (cnt_zero)
  );

  always_comb begin
    state_d      = state_q;
    sign_d       = sign_q;
    reg_write_d  = 1'b0;
    reg_addr_d   = reg_addr_q;
    hd_req_d     = hd_req_q;
    in_wait_d    = in_wait_q;
    err_d        = 1'b0;
    cnt_load     = 1'b0;
    cnt_en       = 1'b0;
    cnt_load_val = RAM_LOAD;

    case (state_q)
      ST_IDLE: begin
        // Requests with wbRegWrite=0 are consumed silently, even with an illegal source.
        if (bus.wbValid && !bus.flush && bus.wbRegWrite) begin
          if (!src_legal(bus.wbSrc)) begin
            err_d = 1'b1;
          end else begin
            sign_d     = bus.wbSrc;
            reg_addr_d = bus.wbRd;
            case (bus.wbSrc)
              SRC_RAM: begin
                state_d      = ST_RAM_WAIT;
                cnt_load     = 1'b1;
                cnt_load_val = RAM_LOAD;
              end
              SRC_HD: begin
                state_d      = ST_HD_REQ;
                hd_req_d     = 1'b1;
                cnt_load     = 1'b1;
                cnt_load_val = HD_LOAD;
              end
              SRC_IN: begin
                state_d   = ST_IN_WAIT;
                in_wait_d = 1'b1;
              end
              default: begin
                state_d     = ST_WRITE;
                reg_write_d = (bus.wbRd != 5'd0);
              end
            endcase
          end
        end
      end

      ST_RAM_WAIT: begin
        if (bus.flush) begin
          state_d = ST_IDLE;
        end else if (cnt_zero) begin
          state_d     = ST_WRITE;
          reg_write_d = (reg_addr_q != 5'd0);
        end else begin
          cnt_en = 1'b1;
        end
      end

      ST_HD_REQ: begin
        // flush beats ack, ack beats timeout
        if (bus.flush) begin
          state_d  = ST_IDLE;
          hd_req_d = 1'b0;
        end else if (bus.hdAck) begin
          state_d     = ST_WRITE;
          hd_req_d    = 1'b0;
          reg_write_d = (reg_addr_q != 5'd0);
        end else if (cnt_zero) begin
          state_d  = ST_IDLE;
          hd_req_d = 1'b0;
          err_d    = 1'b1;
        end else begin
          cnt_en = 1'b1;
        end
      end

      ST_IN_WAIT: begin
        if (bus.flush) begin
          state_d   = ST_IDLE;
          in_wait_d = 1'b0;
        end else if (bus.inEnter) begin
          state_d     = ST_WRITE;
          in_wait_d   = 1'b0;
          reg_write_d = (reg_addr_q != 5'd0);
        end
      end

      ST_WRITE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d   = ST_IDLE;
        hd_req_d  = 1'b0;
        in_wait_d = 1'b0;
      end
    endcase

    // The mux select parks on the ALU whenever the sequencer is (or becomes) idle.
    if (state_d == ST_IDLE) begin
      sign_d = SRC_ALU;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      sign_q      <= SRC_ALU;
      reg_write_q <= 1'b0;
      reg_addr_q  <= 5'd0;
      hd_req_q    <= 1'b0;
      in_wait_q   <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      sign_q      <= sign_d;
      reg_write_q <= reg_write_d;
      reg_addr_q  <= reg_addr_d;
      hd_req_q    <= hd_req_d;
      in_wait_q   <= in_wait_d;
      err_q       <= err_d;
    end
  end

  assign bus.sign     = sign_q;
  assign bus.regWrite = reg_write_q;
  assign bus.regAddr  = reg_addr_q;
  assign bus.hdReq    = hd_req_q;
  assign bus.inWait   = in_wait_q;
  assign bus.err      = err_q;
  assign bus.stall    = (state_q != ST_IDLE);

endmodule

// File: tb/tb_wb_sequencer.sv
// tb_wb_sequencer: two sequencers (default timing, and RAM_LAT=1/HD_TIMEOUT=4)
// driven with identical stimulus and compared every cycle against a
// request-age reference model, plus directed scenario checks.
module tb_wb_sequencer;

  logic clk;
  logic rst_n;

  logic       wbValid;
  logic [2:0] wbSrc;
  logic [4:0] wbRd;
  logic       wbRegWrite;
  logic       flush;
  logic       hdAck;
  logic       inEnter;

  int checks   = 0;
  int failures = 0;
  bit mon_en   = 0;

  wb_sequencer_if ifa ();
  wb_sequencer_if ifb ();

  assign ifa.wbValid    = wbValid;
  assign ifa.wbSrc      = wbSrc;
  assign ifa.wbRd       = wbRd;
  assign ifa.wbRegWrite = wbRegWrite;
  assign ifa.flush      = flush;
  assign ifa.hdAck      = hdAck;
  assign ifa.inEnter    = inEnter;
  assign ifb.wbValid    = wbValid;
  assign ifb.wbSrc      = wbSrc;
  assign ifb.wbRd       = wbRd;
  assign ifb.wbRegWrite = wbRegWrite;
  assign ifb.flush      = flush;
  assign ifb.hdAck      = hdAck;
  assign ifb.inEnter    = inEnter;

  wb_sequencer u_dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifa)
  );

  wb_sequencer #(.RAM_LAT(1), .HD_TIMEOUT(4)) u_dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // A request is tracked by its source and its age (1 in the first busy
  // cycle). Each source has a simple completion rule in terms of age.
  int         m_lat [2] = '{2, 1};
  int         m_to  [2] = '{255, 4};
  bit         m_busy[2];
  bit         m_wr  [2];
  bit         m_err [2];
  logic [2:0] m_src [2];
  logic [4:0] m_rd  [2];
  int         m_age [2];

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_busy[i] = 0;
      m_wr[i]   = 0;
      m_err[i]  = 0;
      m_src[i]  = 3'd1;
      m_rd[i]   = 5'd0;
      m_age[i]  = 0;
    end
  endtask

  task automatic model_edge();
    if (!rst_n) begin
      model_reset();
      return;
    end
    for (int i = 0; i < 2; i++) begin
      m_err[i] = 0;
      if (!m_busy[i]) begin
        if (wbValid && !flush && wbRegWrite) begin
          if (wbSrc > 3'd4) begin
            m_err[i] = 1;
          end else begin
            m_busy[i] = 1;
            m_src[i]  = wbSrc;
            m_rd[i]   = wbRd;
            m_age[i]  = 1;
            m_wr[i]   = (wbSrc == 3'd1) || (wbSrc == 3'd3);
          end
        end
      end else if (m_wr[i] || flush) begin
        m_busy[i] = 0;
        m_wr[i]   = 0;
      end else if (m_src[i] == 3'd0) begin
        m_age[i]++;
        m_wr[i] = (m_age[i] == m_lat[i] + 1);
      end else if (m_src[i] == 3'd4) begin
        if (hdAck) m_wr[i] = 1;
        else if (m_age[i] == m_to[i]) begin
          m_busy[i] = 0;
          m_err[i]  = 1;
        end else m_age[i]++;
      end else if (m_src[i] == 3'd2) begin
        if (inEnter) m_wr[i] = 1;
        else m_age[i]++;
      end
    end
  endtask

  // {sign, regWrite, regAddr, hdReq, inWait, stall, err}
  function automatic logic [12:0] exp_pack(input int i);
    logic [2:0] s;
    s = m_busy[i] ? m_src[i] : 3'd1;
    return {s,
            m_busy[i] && m_wr[i] && (m_rd[i] != 5'd0),
            m_rd[i],
            m_busy[i] && (m_src[i] == 3'd4) && !m_wr[i],
            m_busy[i] && (m_src[i] == 3'd2) && !m_wr[i],
            m_busy[i],
            m_err[i]};
  endfunction

  logic [12:0] obs [2];
  assign obs[0] = {ifa.sign, ifa.regWrite, ifa.regAddr, ifa.hdReq, ifa.inWait, ifa.stall, ifa.err};
  assign obs[1] = {ifb.sign, ifb.regWrite, ifb.regAddr, ifb.hdReq, ifb.inWait, ifb.stall, ifb.err};

  always @(negedge clk) begin
    if (mon_en) begin
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (obs[i] !== exp_pack(i)) begin
          failures++;
          $display("FAIL model_compare dut%0d t=%0t got=%h expected=%h", i, $time, obs[i], exp_pack(i));
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    wbValid    = 0;
    wbSrc      = 3'd0;
    wbRd       = 5'd0;
    wbRegWrite = 0;
    flush      = 0;
    hdAck      = 0;
    inEnter    = 0;
  endtask

  task automatic issue(input logic [2:0] src, input logic [4:0] rd, input logic rw);
    wbValid    = 1;
    wbSrc      = src;
    wbRd       = rd;
    wbRegWrite = rw;
    tick();
    wbValid    = 0;
    wbRegWrite = 0;
  endtask

  task automatic wait_idle(input int limit, input string name);
    int n;
    n = 0;
    while ((ifa.stall !== 1'b0 || ifb.stall !== 1'b0) && n < limit) begin
      tick();
      n++;
    end
    checks++;
    if (ifa.stall !== 1'b0 || ifb.stall !== 1'b0) begin
      failures++;
      $display("FAIL %s_idle got stall=%b%b expected=00", name, ifa.stall, ifb.stall);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    checks++;
    if (obs[0] !== {3'd1, 10'd0}) begin
      failures++;
      $display("FAIL reset_a got=%h expected=%h", obs[0], {3'd1, 10'd0});
    end
    checks++;
    if (obs[1] !== {3'd1, 10'd0}) begin
      failures++;
      $display("FAIL reset_b got=%h expected=%h", obs[1], {3'd1, 10'd0});
    end
  endtask

  task automatic test_alu();
    issue(3'd1, 5'd5, 1'b1);
    checks++;
    if ({ifa.sign, ifa.regWrite, ifa.regAddr, ifa.stall} !== {3'd1, 1'b1, 5'd5, 1'b1}) begin
      failures++;
      $display("FAIL alu_write got=%h expected=%h", {ifa.sign, ifa.regWrite, ifa.regAddr, ifa.stall}, {3'd1, 1'b1, 5'd5, 1'b1});
    end
    tick();
    checks++;
    if ({ifa.regWrite, ifa.stall} !== 2'b00) begin
      failures++;
      $display("FAIL alu_done got=%b expected=00", {ifa.regWrite, ifa.stall});
    end
  endtask

  task automatic test_ram();
    int rw_at, rw_cnt, st_cnt;
    rw_at = 0; rw_cnt = 0; st_cnt = 0;
    issue(3'd0, 5'd8, 1'b1);
    for (int c = 1; c <= 6; c++) begin
      if (ifa.regWrite === 1'b1) begin rw_at = c; rw_cnt++; end
      if (ifa.stall === 1'b1) st_cnt++;
      if (c == 1) begin
        checks++;
        if (ifa.sign !== 3'd0) begin
          failures++;
          $display("FAIL ram_sign got=%0d expected=0", ifa.sign);
        end
      end
      tick();
    end
    checks++;
    if (rw_at != 3 || rw_cnt != 1) begin
      failures++;
      $display("FAIL ram_write_cycle got=%0d/%0d expected=3/1", rw_at, rw_cnt);
    end
    checks++;
    if (st_cnt != 3) begin
      failures++;
      $display("FAIL ram_stall_cycles got=%0d expected=3", st_cnt);
    end
  endtask

  task automatic test_hd_ack();
    issue(3'd4, 5'd9, 1'b1);
    for (int k = 1; k <= 5; k++) begin
      checks++;
      if (ifa.hdReq !== 1'b1) begin
        failures++;
        $display("FAIL hd_req_high cycle=%0d got=%b expected=1", k, ifa.hdReq);
      end
      if (k == 5) hdAck = 1;
      tick();
    end
    hdAck = 0;
    checks++;
    if ({ifa.hdReq, ifa.regWrite, ifa.regAddr} !== {1'b0, 1'b1, 5'd9}) begin
      failures++;
      $display("FAIL hd_ack_write got=%h expected=%h", {ifa.hdReq, ifa.regWrite, ifa.regAddr}, {1'b0, 1'b1, 5'd9});
    end
    tick();
    wait_idle(20, "hd_ack");
  endtask

  task automatic test_hd_timeout();
    int hd_cnt, err_at;
    bit wr;
    hd_cnt = 0; err_at = 0; wr = 0;
    issue(3'd4, 5'd11, 1'b1);
    for (int c = 1; c <= 8; c++) begin
      if (ifb.hdReq === 1'b1) hd_cnt++;
      if (ifb.err === 1'b1) err_at = c;
      if (ifb.regWrite === 1'b1) wr = 1;
      tick();
    end
    checks++;
    if (hd_cnt != 4 || err_at != 5 || wr) begin
      failures++;
      $display("FAIL hd_timeout got hdreq=%0d err_at=%0d wr=%0d expected=4/5/0", hd_cnt, err_at, wr);
    end
    flush = 1;
    tick();
    flush = 0;
    checks++;
    if ({ifa.stall, ifa.hdReq, ifa.err} !== 3'b000) begin
      failures++;
      $display("FAIL hd_flush_a got=%b expected=000", {ifa.stall, ifa.hdReq, ifa.err});
    end
  endtask

  task automatic test_input();
    issue(3'd2, 5'd3, 1'b1);
    for (int k = 1; k <= 20; k++) begin
      checks++;
      if ({ifa.inWait, ifb.inWait, ifa.regWrite} !== 3'b110) begin
        failures++;
        $display("FAIL in_wait cycle=%0d got=%b expected=110", k, {ifa.inWait, ifb.inWait, ifa.regWrite});
      end
      tick();
    end
    inEnter = 1;
    tick();
    inEnter = 0;
    checks++;
    if ({ifa.inWait, ifa.regWrite, ifa.regAddr} !== {1'b0, 1'b1, 5'd3}) begin
      failures++;
      $display("FAIL in_enter_write got=%h expected=%h", {ifa.inWait, ifa.regWrite, ifa.regAddr}, {1'b0, 1'b1, 5'd3});
    end
    tick();
  endtask

  task automatic test_edges();
    issue(3'd6, 5'd12, 1'b1);
    checks++;
    if ({ifa.err, ifb.err, ifa.stall, ifa.regWrite} !== 4'b1100) begin
      failures++;
      $display("FAIL illegal_src got=%b expected=1100", {ifa.err, ifb.err, ifa.stall, ifa.regWrite});
    end
    tick();
    issue(3'd1, 5'd0, 1'b1);
    checks++;
    if ({ifa.stall, ifa.regWrite} !== 2'b10) begin
      failures++;
      $display("FAIL zero_reg got=%b expected=10", {ifa.stall, ifa.regWrite});
    end
    tick();
    issue(3'd0, 5'd4, 1'b0);
    checks++;
    if ({ifa.stall, ifb.stall} !== 2'b00) begin
      failures++;
      $display("FAIL no_regwrite got=%b expected=00", {ifa.stall, ifb.stall});
    end
    tick();
  endtask

  task automatic test_flush();
    bit bad;
    bad = 0;
    issue(3'd4, 5'd7, 1'b1);
    tick();
    flush = 1;
    tick();
    flush = 0;
    checks++;
    if ({ifa.hdReq, ifa.err, ifa.stall, ifb.hdReq, ifb.err, ifb.stall} !== 6'b0) begin
      failures++;
      $display("FAIL flush_hd got=%b expected=000000", {ifa.hdReq, ifa.err, ifa.stall, ifb.hdReq, ifb.err, ifb.stall});
    end
    for (int c = 0; c < 4; c++) begin
      if (ifa.regWrite === 1'b1 || ifb.regWrite === 1'b1) bad = 1;
      tick();
    end
    checks++;
    if (bad) begin
      failures++;
      $display("FAIL flush_no_write got=1 expected=0");
    end
  endtask

  task automatic test_reset_midop();
    bit bad;
    bad = 0;
    issue(3'd0, 5'd10, 1'b1);
    #2;
    rst_n = 0;
    model_reset();
    #1;
    checks++;
    if (obs[0] !== {3'd1, 10'd0} || obs[1] !== {3'd1, 10'd0}) begin
      failures++;
      $display("FAIL reset_midop got=%h/%h expected=%h", obs[0], obs[1], {3'd1, 10'd0});
    end
    @(negedge clk);
    tick();
    rst_n = 1;
    for (int c = 0; c < 5; c++) begin
      if (ifa.regWrite === 1'b1 || ifb.regWrite === 1'b1) bad = 1;
      tick();
    end
    checks++;
    if (bad) begin
      failures++;
      $display("FAIL reset_no_write got=1 expected=0");
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 600; n++) begin
      wbValid    = ($urandom_range(0, 1) == 1);
      wbSrc      = ($urandom_range(0, 9) < 8) ? 3'($urandom_range(0, 4)) : 3'($urandom_range(5, 7));
      wbRd       = 5'($urandom_range(0, 31));
      wbRegWrite = ($urandom_range(0, 9) != 0);
      flush      = ($urandom_range(0, 19) == 0);
      hdAck      = ($urandom_range(0, 3) == 0);
      inEnter    = ($urandom_range(0, 4) == 0);
      tick();
    end
    clear_inputs();
    flush = 1;
    tick();
    flush = 0;
    wait_idle(10, "random");
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1;
    clear_inputs();
    model_reset();
    #1 rst_n = 0;
    #3;
    test_reset();
    @(negedge clk);
    rst_n  = 1;
    mon_en = 1;
    tick();
    test_alu();
    test_ram();
    test_hd_ack();
    test_hd_timeout();
    test_input();
    test_edges();
    test_flush();
    test_reset_midop();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wb_sequencer.md
Name: wb_sequencer

Overview:
- Writeback controller for the multi-cycle MIPS datapath.
- Accepts one writeback request at a time and drives the 3-bit source select of the writeback data mux (0 RAM, 1 ALU, 2 input switches, 3 sign-extend, 4 HD).
- Waits for slow sources (RAM latency, HD handshake, user input), then issues a single register-file write pulse.
- Stalls upstream while busy.

Parameters:
- RAM_LAT, 2, cycles from acceptance until RAM data is valid (legal range 1..15)
- HD_TIMEOUT, 255, maximum cycles waiting for hdAck before abort (legal range 1..255)

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- wbValid  in  1  writeback request present
- wbSrc  in  3  requested source (0..4 legal)
- wbRd  in  5  destination register
- wbRegWrite  in  1  request writes a register
- flush  in  1  synchronous abort of the request in flight
- hdAck  in  1  HD data valid (level)
- inEnter  in  1  user confirm, externally synchronised, one-cycle pulse
- sign  out  3  writeback mux select
- regWrite  out  1  register-file write enable, one-cycle pulse
- regAddr  out  5  register-file write address
- hdReq  out  1  HD read request
- inWait  out  1  waiting for user input (LED)
- stall  out  1  upstream must hold its request
- err  out  1  one-cycle pulse: HD timeout or illegal wbSrc

Behaviour:
- All outputs are registered except stall.
- stall = (state != IDLE).
- Reset (async, rst_n low): state IDLE, sign=1, counter=0, all other outputs 0.
- Reset asserted mid-operation aborts immediately; no write is issued.
- States: IDLE, RAM_WAIT, HD_REQ, IN_WAIT, WRITE.
- IDLE: wbValid is sampled only in this state.
  - wbRegWrite=0: request consumed; no state change; no stall.
  - wbSrc 5..7: err pulses next cycle; request dropped; remain IDLE.
  - Otherwise latch wbSrc into sign and wbRd into regAddr, then:
    - src 1/3 -> WRITE
    - src 0 -> RAM_WAIT, counter = RAM_LAT-1
    - src 4 -> HD_REQ, hdReq=1, counter = HD_TIMEOUT-1
    - src 2 -> IN_WAIT, inWait=1
- RAM_WAIT: decrement counter; at 0 -> WRITE. Acceptance-to-write-pulse latency is RAM_LAT+1 cycles.
- HD_REQ: hdReq held high.
  - hdAck=1 -> WRITE, hdReq=0.
  - Counter reaches 0 with no ack -> IDLE, hdReq=0, err pulse, no write.
  - hdAck and timeout in the same cycle: ack wins.
- IN_WAIT: inEnter=1 -> WRITE, inWait=0. No timeout.
- WRITE: regWrite=1 for exactly one cycle, with sign and regAddr stable. Then -> IDLE.
  - regAddr=0 ($zero): regWrite stays 0; sequencing is otherwise unchanged.
- Fast sources (1/3) take 2 cycles per request: the write pulse occurs 1 cycle after acceptance.
- In IDLE, sign returns to 1 on the cycle after WRITE. regAddr holds its last value.
- flush in any non-IDLE state -> IDLE next cycle; hdReq/inWait/regWrite cleared; no err.
- flush has priority over hdAck, inEnter and timeout.
- flush in IDLE blocks acceptance that cycle.
- sign never changes while the state is not IDLE.

Decomposition:
- Package wb_pkg:
  - source encodings SRC_RAM=0, SRC_ALU=1, SRC_IN=2, SRC_EXT=3, SRC_HD=4
  - state encoding localparams
  - counter width (8)
- One sub-module, wb_wait_counter: loadable 8-bit down-counter with load, enable and zero flag. It is shared between RAM latency and HD timeout.

Test Plan:
1. ALU request: wbSrc=1, wbRd=5, wbRegWrite=1, one cycle -> sign=1, regWrite=1 and regAddr=5 on cycle 2; stall high for 1 cycle only.
2. RAM request, RAM_LAT=2, wbRd=8 -> sign=0 from cycle 1; regWrite pulse at cycle 3; stall high cycles 1-3.
3. HD request, hdAck raised 5 cycles after hdReq -> hdReq high 5 cycles, then drops; regWrite pulse the following cycle. Repeat with HD_TIMEOUT=4 and no ack -> err pulse after 4 cycles, no regWrite, hdReq low.
4. Input request, wbRd=3 -> inWait held for 20 cycles; inEnter pulse -> regWrite the next cycle, inWait low.
5. Edge cases: wbSrc=6 -> err pulse, no stall, no write. wbSrc=1 with wbRd=0 -> no regWrite, stall for 1 cycle. wbRegWrite=0 -> no stall.
6. Aborts: flush in HD_REQ on cycle 2 -> IDLE, hdReq low, no err, no write. rst_n low in RAM_WAIT -> all outputs at reset values immediately; no regWrite after release.
